// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: drives an external N-bit adder one slice per cycle,
// LSB first, to build a WORDS*N-bit add/subtract with carry-out and signed overflow.
`default_nettype none

module multiword_add_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  input  logic                 sub,
  output logic [N-1:0]         add_x,
  output logic [N-1:0]         add_y,
  output logic                 add_cin,
  input  logic [N-1:0]         add_s,
  input  logic                 add_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W     = N * WORDS;
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SLOTS = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;
  logic            carry;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] sel;

  logic [N-1:0] a_sl [SLOTS];
  logic [N-1:0] b_sl [SLOTS];

  // Pad the slice table to a power of two so any idx value selects something defined.
  generate
    for (genvar g = 0; g < SLOTS; g++) begin : g_slice
      if (g < WORDS) begin : g_real
        assign a_sl[g] = a_reg[g*N +: N];
        assign b_sl[g] = b_reg[g*N +: N];
      end else begin : g_pad
        assign a_sl[g] = '0;
        assign b_sl[g] = '0;
      end
    end
  endgenerate

  assign sel         = (state == RUN) ? idx : '0;
  assign add_x       = a_sl[sel];
  assign add_y       = b_sl[sel] ^ {N{sub_reg}};
  assign add_cin     = (state == RUN) && carry;
  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            carry   <= sub | cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IDXW'(i)) sum[i*N +: N] <= add_s;
          end
          carry <= add_cout;
          if (idx == LAST) begin
            cout     <= add_cout;
            // Signed overflow: operands share a sign that the result's MSB lacks.
            overflow <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) && (add_s[N-1] != a_reg[W-1]);
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequential front/back stage for the N-bit prefix adder. It accepts one wide operand pair of N*WORDS bits through a valid/ready handshake and presents one N-bit slice per cycle to the combinational adder, least-significant slice first. It chains the carry through a register, collects the adder's sum slices into a wide result, and returns the result through a second valid/ready handshake. This lets the same N-bit adder serve datapaths WORDS times wider. It also provides subtraction and signed-overflow detection.

## Interface
- N, 8: slice width. Must equal the attached adder's N.
- WORDS, 4: number of slices, ≥1. Total width W = N*WORDS.
- clk  in  1: single clock. All state updates on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- start_valid  in  1: operand pair offered.
- start_ready  out  1: sequencer can accept an operand pair (high only in IDLE).
- a  in  W: first operand.
- b  in  W: second operand.
- cin  in  1: carry-in for add. Ignored when sub=1.
- sub  in  1: 1 computes a−b (b inverted, initial carry forced to 1).
- add_x  out  N: adder x input, slice idx of the a register.
- add_y  out  N: adder y input, slice idx of the b register, inverted if the sub register is set.
- add_cin  out  1: adder Cin, from the carry register.
- add_s  in  N: adder sum output.
- add_cout  in  1: adder Cout.
- res_valid  out  1: result available (high only in DONE).
- res_ready  in  1: consumer takes the result.
- sum  out  W: result.
- cout  out  1: final carry-out. For subtraction, 1 means no borrow.
- overflow  out  1: two's-complement signed overflow of the W-bit operation.

## Operation
- FSM with three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**:
  - start_ready=1.
  - On start_valid&&start_ready: capture a, b and sub; carry register ← (sub ? 1 : cin); idx ← 0; go to RUN.
- **RUN**, each cycle:
  - add_x, add_y and add_cin are driven combinationally from the registers; the adder settles within the cycle.
  - At the clock edge: sum[idx*N +: N] ← add_s; carry ← add_cout.
  - If idx==WORDS−1: cout ← add_cout, overflow ← computed, go to DONE. Otherwise idx ← idx+1.
- **Overflow**: overflow = (a[W−1] == ye[W−1]) && (add_s[N−1] != a[W−1]), evaluated on the last slice. Here ye is the effective y operand (b, or ~b for subtraction).
- **DONE**:
  - res_valid=1. sum, cout and overflow are stable.
  - On res_ready go to IDLE.
  - start_valid is ignored (start_ready=0).
- **Result hold**: sum, cout and overflow hold their values from DONE through the following IDLE period. They are overwritten slice by slice during the next RUN and are meaningful only while res_valid=1.
- **Output decoding**: add_x, add_y and add_cin are valid only in RUN. In IDLE and DONE they show slice 0 with carry 0.
- **Width rules**:
  - idx is $clog2(WORDS) bits wide, minimum 1.
  - No modular wrap of idx is permitted beyond WORDS−1.
  - With WORDS=1, RUN lasts exactly one cycle.

## Timing
- **Reset values**:
  - state=IDLE, idx=0, carry=0.
  - sum=0, cout=0, overflow=0.
  - res_valid=0, start_ready=1.
  - add_x=0, add_y=0, add_cin=0 (sub register cleared).
- **Reset response**: assertion of rst_n takes effect immediately (asynchronously), including in the middle of RUN or DONE. Any in-flight operation is discarded with no result.
- **Latency**: acceptance edge at cycle k; RUN occupies cycles k+1 … k+WORDS; res_valid rises after edge k+WORDS.
- **Result handshake**:
  - res_valid stays high until the edge where res_ready=1.
  - It deasserts, and start_ready asserts, after that edge.
  - There is no same-cycle result-to-accept bypass.
- **Throughput**: the minimum acceptance-to-acceptance interval is WORDS+2 cycles when res_ready is held at 1.
- **Handshake rule**: no input handshake completes while the block is in RUN or DONE, so start_valid may be held high without side effects.

## Test plan
- **Slice carry**: N=8, WORDS=4, a=0x000000FF, b=0x00000001, cin=0, sub=0 → sum=0x00000100, cout=0, overflow=0. res_valid rises exactly 4 cycles after the acceptance edge.
- **Full carry ripple**: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0. add_cin must be 1 in RUN cycles 2–4.
- **Subtract and overflow**:
  - a=5, b=7, sub=1, cin=1 (cin ignored) → sum=0xFFFFFFFE, cout=0, overflow=0.
  - a=0x80000000, b=1, sub=1 → 0x7FFFFFFF, cout=1, overflow=1.
  - a=0x7FFFFFFF, b=1, add → 0x80000000, cout=0, overflow=1.
- **Backpressure**:
  - Hold res_ready=0 for 10 cycles in DONE: res_valid, sum, cout and overflow stay stable; start_ready=0; start_valid pulses with a=1, b=1 are ignored.
  - Then raise res_ready=1: start_ready=1 on the next cycle, and a new op completes correctly.
- **Back-to-back**: keep start_valid and res_ready at 1 with three different operand pairs → acceptances are spaced exactly 6 cycles apart, and all three results are correct.
- **Reset mid-operation**: drop rst_n during the 2nd RUN cycle → res_valid=0, start_ready=1, sum=0 immediately. After release, the op a=3, b=4 gives sum=7 with no residue from the aborted op.
